bus_host_adapter: RTL

BUS_HOST_ADAPTER -- requirements
Module: bus_host_adapter

---
 rtl/bus_pkg.sv | 58 +++++
 rtl/load_align.sv | 37 +++
 rtl/bus_host_adapter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus host adapter: bus opcodes, access sizes,
// FSM states and small helpers for alignment, lane masks and store data.
package bus_pkg;

    // A-channel opcodes
    localparam logic [2:0] GET      = 3'b100;
    localparam logic [2:0] PUT_FULL = 3'b000;
    // D-channel opcodes
    localparam logic [2:0] ACK      = 3'b000;
    localparam logic [2:0] ACK_DATA = 3'b001;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_e;

    // A half must sit on an even address, a word on a multiple of four.
    // The unused size code 2'b11 is handled like a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic result;
        case (size)
            SIZE_BYTE: result = 1'b0;
            SIZE_HALF: result = addr_lo[0];
            default:   result = (addr_lo != 2'b00);
        endcase
        return result;
    endfunction

    // Byte lanes touched by an access.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] result;
        case (size)
            SIZE_BYTE: result = 4'b0001 << addr_lo;
            SIZE_HALF: result = 4'b0011 << addr_lo;
            default:   result = 4'b1111;
        endcase
        return result;
    endfunction

    // Store data replicated across all lanes so the mask alone picks the bytes.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] result;
        case (size)
            SIZE_BYTE: result = {4{wdata[7:0]}};
            SIZE_HALF: result = {2{wdata[15:0]}};
            default:   result = wdata;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane selection: picks the addressed byte or half out of a bus word
// and sign- or zero-extends it to 32 bits. Purely combinational.
module load_align
    import bus_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0] lane [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = data[8*gi +: 8];
        end
    endgenerate

    // Select the addressed sub-word and extend it.
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = lane[addr];
        half_sel = addr[1] ? data[31:16] : data[15:0];
        result   = data;
        case (size)
            SIZE_BYTE: result = is_unsigned ? {24'h0, byte_sel}
                                            : {{24{byte_sel[7]}}, byte_sel};
            SIZE_HALF: result = is_unsigned ? {16'h0, half_sel}
                                            : {{16{half_sel[15]}}, half_sel};
            default:   result = data;
        endcase
    end

endmodule

// File: rtl/bus_host_adapter.sv
// Bus host adapter: turns single core load/store requests into one A-channel
// transaction and one D-channel response, returning extended load data or
// an error to the core.
// Optional watchdog: define BUS_HOST_TIMEOUT_EN to abort an ISSUE that sees
// no d_valid within TIMEOUT_CYCLES cycles (response flagged as error).
module bus_host_adapter
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // core request
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    // core response
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    // bus A channel
    output logic                  a_valid,
    output logic [ADDR_WIDTH-1:0] a_address,
    output logic [2:0]            a_opcode,
    output logic [31:0]           a_data,
    output logic [1:0]            a_size,
    output logic [3:0]            a_mask,
    // bus D channel
    input  logic                  d_valid,
    input  logic [2:0]            d_opcode,
    input  logic [1:0]            d_size,
    input  logic [31:0]           d_data
);

    // The datapath and lane logic are built for a 32-bit bus only.
    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("bus_host_adapter: DATA_WIDTH must be 32");
        end
        if (ADDR_WIDTH < 2) begin : g_bad_addr_width
            $error("bus_host_adapter: ADDR_WIDTH must be at least 2");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("bus_host_adapter: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    state_e                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                  we_reg, we_next;
    logic [1:0]            size_reg, size_next;
    logic                  unsigned_reg, unsigned_next;
    logic [3:0]            mask_reg, mask_next;
    logic [31:0]           wdata_reg, wdata_next;
    logic [31:0]           rdata_reg, rdata_next;
    logic                  err_reg, err_next;
    logic [31:0]           load_result;
    logic [2:0]            exp_opcode;
    logic                  d_bad;

`ifdef BUS_HOST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_reg, cnt_next;
`endif

    load_align u_load_align (
        .data        (d_data),
        .addr        (addr_reg[1:0]),
        .size        (size_reg),
        .is_unsigned (unsigned_reg),
        .result      (load_result)
    );

    // A reply is bad if its opcode does not match the request kind, or if it
    // reports a different size than was asked for.
    assign exp_opcode = we_reg ? ACK : ACK_DATA;
    assign d_bad      = (d_opcode != exp_opcode) || (d_size != size_reg);

    // State and request registers; reset drops a_valid at once since it is
    // decoded straight from state_reg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            size_reg     <= 2'b00;
            unsigned_reg <= 1'b0;
            mask_reg     <= 4'b0000;
            wdata_reg    <= 32'h0;
            rdata_reg    <= 32'h0;
            err_reg      <= 1'b0;
`ifdef BUS_HOST_TIMEOUT_EN
            cnt_reg      <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            we_reg       <= we_next;
            size_reg     <= size_next;
            unsigned_reg <= unsigned_next;
            mask_reg     <= mask_next;
            wdata_reg    <= wdata_next;
            rdata_reg    <= rdata_next;
            err_reg      <= err_next;
`ifdef BUS_HOST_TIMEOUT_EN
            cnt_reg      <= cnt_next;
`endif
        end
    end

    // Next-state and datapath update for IDLE -> ISSUE/RESP -> IDLE.
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        we_next       = we_reg;
        size_next     = size_reg;
        unsigned_next = unsigned_reg;
        mask_next     = mask_reg;
        wdata_next    = wdata_reg;
        rdata_next    = rdata_reg;
        err_next      = err_reg;
`ifdef BUS_HOST_TIMEOUT_EN
        cnt_next      = cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    addr_next     = req_addr;
                    we_next       = req_we;
                    size_next     = req_size;
                    unsigned_next = req_unsigned;
                    mask_next     = lane_mask(req_size, req_addr[1:0]);
                    wdata_next    = req_we ? store_data(req_size, req_wdata) : 32'h0;
                    rdata_next    = 32'h0;
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        // Never reaches the bus; report the error directly.
                        err_next   = 1'b1;
                        state_next = RESP;
                    end else begin
                        err_next   = 1'b0;
                        state_next = ISSUE;
`ifdef BUS_HOST_TIMEOUT_EN
                        cnt_next   = '0;
`endif
                    end
                end
            end
            ISSUE: begin
                if (d_valid) begin
                    err_next   = d_bad;
                    rdata_next = (we_reg || d_bad) ? 32'h0 : load_result;
                    state_next = RESP;
                end
`ifdef BUS_HOST_TIMEOUT_EN
                else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Last allowed ISSUE cycle without a reply: give up.
                    err_next   = 1'b1;
                    rdata_next = 32'h0;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end
            RESP: begin
                err_next   = 1'b0;
                rdata_next = 32'h0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready = (state_reg == IDLE);
    assign a_valid   = (state_reg == ISSUE);
    assign rsp_valid = (state_reg == RESP);

    // A fields are held from the accepted request and forced to 0 outside ISSUE.
    assign a_address = a_valid ? addr_reg : '0;
    assign a_opcode  = a_valid ? (we_reg ? PUT_FULL : GET) : 3'b000;
    assign a_data    = a_valid ? wdata_reg : 32'h0;
    assign a_size    = a_valid ? size_reg : 2'b00;
    assign a_mask    = a_valid ? mask_reg : 4'b0000;

    // Response payload is only visible during the one RESP cycle.
    assign rsp_rdata = rsp_valid ? rdata_reg : 32'h0;
    assign rsp_err   = rsp_valid & err_reg;

endmodule
